// File: rtl/mem_to_axi_pkg.sv
// mem_to_axi_pkg: shared FSM states, AXI response codes and size helper for the memory-to-AXI bridge
package mem_to_axi_pkg;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP} state_e;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR = 2'b01;
  function automatic logic [2:0] axi_size(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction
endpackage

// File: rtl/mem_to_axi_master_if.sv
// mem_to_axi_master_if: single-beat AXI4 channel bundle with master/slave views
interface mem_to_axi_master_if #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned UserWidth = 1
);
  logic                   aw_valid, aw_ready, aw_lock;
  logic [AddrWidth-1:0]   aw_addr;
  logic [IdWidth-1:0]     aw_id;
  logic [7:0]             aw_len;
  logic [2:0]             aw_size, aw_prot;
  logic [1:0]             aw_burst;
  logic [3:0]             aw_cache, aw_qos, aw_region;
  logic [5:0]             aw_atop;
  logic [UserWidth-1:0]   aw_user;
  logic                   w_valid, w_ready, w_last;
  logic [DataWidth-1:0]   w_data;
  logic [DataWidth/8-1:0] w_strb;
  logic [UserWidth-1:0]   w_user;
  logic                   b_valid, b_ready;
  logic [1:0]             b_resp;
  logic                   ar_valid, ar_ready, ar_lock;
  logic [AddrWidth-1:0]   ar_addr;
  logic [IdWidth-1:0]     ar_id;
  logic [7:0]             ar_len;
  logic [2:0]             ar_size, ar_prot;
  logic [1:0]             ar_burst;
  logic [3:0]             ar_cache, ar_qos, ar_region;
  logic [UserWidth-1:0]   ar_user;
  logic                   r_valid, r_ready, r_last;
  logic [DataWidth-1:0]   r_data;
  logic [1:0]             r_resp;
  modport master (
    output aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last, w_user,
    input  w_ready,
    input  b_valid, b_resp,
    output b_ready,
    output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user,
    input  ar_ready,
    input  r_valid, r_data, r_resp, r_last,
    output r_ready
  );
  modport slave (
    input  aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last, w_user,
    output w_ready,
    output b_valid, b_resp,
    input  b_ready,
    input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user,
    output ar_ready,
    output r_valid, r_data, r_resp, r_last,
    input  r_ready
  );
endinterface

// File: rtl/mem_to_axi_master.sv
// mem_to_axi_master: req/gnt memory port to single-beat AXI4 master, one transaction outstanding
module mem_to_axi_master
  import mem_to_axi_pkg::*;
#(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned UserWidth = 1,
  parameter int unsigned AxiId     = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic                   we_i,
  input  logic [DataWidth/8-1:0] be_i,
  input  logic [DataWidth-1:0]   wdata_i,
  output logic                   rvalid_o,
  output logic [DataWidth-1:0]   rdata_o,
  output logic                   err_o,
  mem_to_axi_master_if.master    axi
);
  localparam int unsigned OffW = $clog2(DataWidth / 8);

  state_e                 state_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [DataWidth/8-1:0] be_q;
  logic [DataWidth-1:0]   wdata_q, rdata_q;
  logic                   aw_valid_q, w_valid_q, ar_valid_q, b_ready_q, r_ready_q;
  logic                   aw_done_q, w_done_q, rvalid_q, err_q;
  logic                   aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_done_d, w_done_d;

  assign gnt_o     = req_i & (state_q == IDLE) & ~rst_i;
  assign aw_hs     = aw_valid_q & axi.aw_ready;
  assign w_hs      = w_valid_q & axi.w_ready;
  assign ar_hs     = ar_valid_q & axi.ar_ready;
  assign b_hs      = b_ready_q & axi.b_valid;
  assign r_hs      = r_ready_q & axi.r_valid;
  assign aw_done_d = aw_done_q | aw_hs;
  assign w_done_d  = w_done_q | w_hs;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: if (gnt_o) begin
          // byte lanes are selected by the strobe alone, so the address is beat-aligned
          addr_q     <= (addr_i >> OffW) << OffW;
          be_q       <= be_i;
          wdata_q    <= wdata_i;
          aw_done_q  <= 1'b0;
          w_done_q   <= 1'b0;
          aw_valid_q <= we_i;
          w_valid_q  <= we_i;
          ar_valid_q <= ~we_i;
          state_q    <= we_i ? WR_REQ : RD_REQ;
        end
        WR_REQ: begin
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (aw_hs) aw_valid_q <= 1'b0;
          if (w_hs) w_valid_q <= 1'b0;
          if (aw_done_d && w_done_d) begin
            b_ready_q <= 1'b1;
            state_q   <= WR_RSP;
          end
        end
        WR_RSP: if (b_hs) begin
          b_ready_q <= 1'b0;
          err_q     <= axi.b_resp != OKAY;
          rvalid_q  <= 1'b1;
          state_q   <= IDLE;
        end
        RD_REQ: if (ar_hs) begin
          ar_valid_q <= 1'b0;
          r_ready_q  <= 1'b1;
          state_q    <= RD_RSP;
        end
        RD_RSP: if (r_hs) begin
          r_ready_q <= 1'b0;
          rdata_q   <= axi.r_data;
          err_q     <= (axi.r_resp != OKAY) | ~axi.r_last;
          rvalid_q  <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rvalid_o      = rvalid_q;
  assign rdata_o       = rdata_q;
  assign err_o         = err_q;
  assign axi.aw_valid  = aw_valid_q;
  assign axi.aw_addr   = addr_q;
  assign axi.aw_id     = IdWidth'(AxiId);
  assign axi.aw_len    = 8'd0;
  assign axi.aw_size   = axi_size(DataWidth);
  assign axi.aw_burst  = BURST_INCR;
  assign axi.aw_lock   = 1'b0;
  assign axi.aw_cache  = 4'd0;
  assign axi.aw_prot   = 3'd0;
  assign axi.aw_qos    = 4'd0;
  assign axi.aw_region = 4'd0;
  assign axi.aw_atop   = 6'd0;
  assign axi.aw_user   = '0;
  assign axi.w_valid   = w_valid_q;
  assign axi.w_data    = wdata_q;
  assign axi.w_strb    = be_q;
  assign axi.w_last    = 1'b1;
  assign axi.w_user    = '0;
  assign axi.b_ready   = b_ready_q;
  assign axi.ar_valid  = ar_valid_q;
  assign axi.ar_addr   = addr_q;
  assign axi.ar_id     = IdWidth'(AxiId);
  assign axi.ar_len    = 8'd0;
  assign axi.ar_size   = axi_size(DataWidth);
  assign axi.ar_burst  = BURST_INCR;
  assign axi.ar_lock   = 1'b0;
  assign axi.ar_cache  = 4'd0;
  assign axi.ar_prot   = 3'd0;
  assign axi.ar_qos    = 4'd0;
  assign axi.ar_region = 4'd0;
  assign axi.ar_user   = '0;
  assign axi.r_ready   = r_ready_q;
endmodule

// File: tb/tb_mem_to_axi_master.sv
// tb_mem_to_axi_master: directed scoreboard bench with a latency-configurable AXI slave model
module tb_mem_to_axi_master;
  import mem_to_axi_pkg::*;

  typedef struct { logic err; logic [63:0] rdata; logic chk; int lat; } cmp_t;
  typedef struct { logic [63:0] data; logic [7:0] strb; } w_t;

  logic        clk_i = 1'b0, rst_i = 1'b1, req_i = 1'b0, we_i = 1'b0;
  logic [63:0] addr_i = '0, wdata_i = '0;
  logic [7:0]  be_i = '0;
  logic        gnt_o, rvalid_o, err_o;
  logic [63:0] rdata_o;

  mem_to_axi_master_if #(.AddrWidth(64), .DataWidth(64), .IdWidth(4), .UserWidth(1)) axi ();

  mem_to_axi_master #(.AddrWidth(64), .DataWidth(64), .IdWidth(4), .UserWidth(1), .AxiId(0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o), .axi(axi)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0, n_err = 0, cyc = 0;
  int aw_lat = 0, w_lat = 0, b_lat = 0, r_lat = 0;
  logic [1:0]  b_resp_cfg = OKAY, r_resp_cfg = OKAY;
  logic        r_last_cfg = 1'b1;
  logic [63:0] r_data_cfg = '0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, r_cnt = 0, b_pend = 0, r_pend = 0;
  bit b_evt = 0, r_evt = 0, aw_ok = 0, w_ok = 0;
  int aw_hs_n = 0, w_hs_n = 0, aw_vcyc = 0, w_vcyc = 0;
  int last_waits = 0;
  logic rv_at_gnt = 1'b0;
  logic [63:0] exp_aw[$], exp_ar[$];
  w_t   exp_w[$];
  cmp_t cmp_q[$];
  int   gq[$];
  cmp_t mc;
  w_t   mw;
  int   mg;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  // AXI slave: ready/valid driven on the falling edge, handshake events come from the monitor
  initial begin
    {axi.aw_ready, axi.w_ready, axi.ar_ready, axi.b_valid, axi.r_valid, axi.r_last} = '0;
    axi.b_resp = OKAY;
    axi.r_resp = OKAY;
    axi.r_data = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        {axi.aw_ready, axi.w_ready, axi.ar_ready, axi.b_valid, axi.r_valid} = '0;
        {aw_cnt, w_cnt, b_cnt, r_cnt, b_pend, r_pend} = '0;
        {b_evt, r_evt} = '0;
      end else begin
        if (axi.aw_valid) begin
          if (aw_cnt >= aw_lat) axi.aw_ready = 1'b1; else begin aw_cnt++; axi.aw_ready = 1'b0; end
        end else begin axi.aw_ready = 1'b0; aw_cnt = 0; end
        if (axi.w_valid) begin
          if (w_cnt >= w_lat) axi.w_ready = 1'b1; else begin w_cnt++; axi.w_ready = 1'b0; end
        end else begin axi.w_ready = 1'b0; w_cnt = 0; end
        axi.ar_ready = axi.ar_valid;
        if (b_evt) begin axi.b_valid = 1'b0; b_evt = 0; b_pend--; b_cnt = 0; end
        if (!axi.b_valid && b_pend > 0) begin
          if (b_cnt >= b_lat) begin axi.b_valid = 1'b1; axi.b_resp = b_resp_cfg; end else b_cnt++;
        end
        if (r_evt) begin axi.r_valid = 1'b0; r_evt = 0; r_pend--; r_cnt = 0; end
        if (!axi.r_valid && r_pend > 0) begin
          if (r_cnt >= r_lat) begin
            axi.r_valid = 1'b1;
            axi.r_data  = r_data_cfg;
            axi.r_resp  = r_resp_cfg;
            axi.r_last  = r_last_cfg;
          end else r_cnt++;
        end
      end
    end
  end

  // monitor: samples 2 time units after the falling edge, pops the scoreboard on every event
  initial forever begin
    @(negedge clk_i);
    #2;
    if (rst_i) begin
      aw_ok = 0;
      w_ok = 0;
    end else begin
      if (axi.aw_valid) aw_vcyc++;
      if (axi.w_valid) w_vcyc++;
      if (axi.aw_valid && axi.aw_ready) begin
        aw_hs_n++;
        aw_ok = 1;
        if (exp_aw.size() == 0) fail("aw unexpected handshake");
        else check("aw_addr", axi.aw_addr, exp_aw.pop_front());
      end
      if (axi.w_valid && axi.w_ready) begin
        w_hs_n++;
        w_ok = 1;
        if (exp_w.size() == 0) fail("w unexpected handshake");
        else begin
          mw = exp_w.pop_front();
          check("w_data", axi.w_data, mw.data);
          check("w_strb", 64'(axi.w_strb), 64'(mw.strb));
        end
      end
      if (aw_ok && w_ok) begin aw_ok = 0; w_ok = 0; b_pend++; end
      if (axi.ar_valid && axi.ar_ready) begin
        r_pend++;
        if (exp_ar.size() == 0) fail("ar unexpected handshake");
        else check("ar_addr", axi.ar_addr, exp_ar.pop_front());
      end
      if (axi.b_valid && axi.b_ready) b_evt = 1;
      if (axi.r_valid && axi.r_ready) r_evt = 1;
      if (rvalid_o) begin
        if (cmp_q.size() == 0) fail("rvalid unexpected completion");
        else begin
          mc = cmp_q.pop_front();
          mg = (gq.size() != 0) ? gq.pop_front() : -100;
          check("err_o", 64'(err_o), 64'(mc.err));
          if (mc.chk) check("rdata_o", rdata_o, mc.rdata);
          if (mc.lat != 0) check("latency", 64'(cyc - mg), 64'(mc.lat));
        end
      end
    end
  end

  task automatic issue(input logic [63:0] a, input logic w, input logic [7:0] be, input logic [63:0] d,
                       input logic [63:0] ea, input logic eerr, input logic [63:0] erd, input int lat,
                       input bit push);
    bit got = 0;
    if (push) begin
      if (w) begin
        exp_aw.push_back(ea);
        exp_w.push_back('{d, be});
      end else exp_ar.push_back(ea);
      cmp_q.push_back('{eerr, erd, !w, lat});
    end
    @(negedge clk_i);
    req_i = 1'b1; addr_i = a; we_i = w; be_i = be; wdata_i = d;
    last_waits = 0;
    for (int i = 0; i < 64 && !got; i++) begin
      #2;
      if (gnt_o) got = 1;
      else begin last_waits++; @(negedge clk_i); end
    end
    if (!got) fail("grant timeout");
    else begin
      rv_at_gnt = rvalid_o;
      if (push) gq.push_back(cyc);
    end
    @(negedge clk_i);
    req_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && cmp_q.size() != 0; i++) @(negedge clk_i);
    if (cmp_q.size() != 0) begin
      fail("completion timeout");
      cmp_q.delete(); gq.delete(); exp_aw.delete(); exp_w.delete(); exp_ar.delete();
    end
    @(negedge clk_i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #2;
    check("reset handshake outs", {axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready}, 0);
    check("reset gnt/rvalid/err", {gnt_o, rvalid_o, err_o}, 0);
    check("reset rdata", rdata_o, 0);
    check("reset aw const", {axi.aw_len, axi.aw_size, axi.aw_burst, axi.aw_id}, {8'd0, 3'd3, 2'b01, 4'd0});
    check("reset ar const", {axi.ar_len, axi.ar_size, axi.ar_burst, axi.ar_id}, {8'd0, 3'd3, 2'b01, 4'd0});

    issue(64'h8000_0010, 1, 8'h0F, 64'hDEADBEEF_CAFEF00D, 64'h8000_0010, 0, 0, 3, 1);
    check("write gnt cycle0", last_waits, 0);
    wait_idle();

    r_lat = 2; r_data_cfg = 64'h1122334455667788;
    issue(64'h8000_0100, 0, 8'h00, 0, 64'h8000_0100, 0, 64'h1122334455667788, 5, 1);
    wait_idle();
    r_lat = 0;

    {aw_hs_n, w_hs_n, aw_vcyc, w_vcyc} = '0;
    w_lat = 5;
    issue(64'h8000_0020, 1, 8'hFF, 64'h0123456789ABCDEF, 64'h8000_0020, 0, 0, 8, 1);
    wait_idle();
    check("caseA aw count", aw_hs_n, 1);
    check("caseA w count", w_hs_n, 1);
    check("caseA aw valid cycles", aw_vcyc, 1);
    check("caseA w valid cycles", w_vcyc, 6);

    {aw_hs_n, w_hs_n, aw_vcyc, w_vcyc} = '0;
    w_lat = 0; aw_lat = 5;
    issue(64'h8000_0028, 1, 8'h3C, 64'hFEDCBA9876543210, 64'h8000_0028, 0, 0, 8, 1);
    wait_idle();
    check("caseB aw count", aw_hs_n, 1);
    check("caseB w count", w_hs_n, 1);
    check("caseB aw valid cycles", aw_vcyc, 6);
    check("caseB w valid cycles", w_vcyc, 1);
    aw_lat = 0;

    b_resp_cfg = SLVERR;
    issue(64'h8000_0030, 1, 8'hF0, 64'h5555AAAA5555AAAA, 64'h8000_0030, 1, 0, 3, 1);
    wait_idle();
    b_resp_cfg = OKAY;

    r_last_cfg = 1'b0; r_data_cfg = 64'hA5A5A5A5_5A5A5A5A;
    issue(64'h8000_0040, 0, 8'h00, 0, 64'h8000_0040, 1, 64'hA5A5A5A5_5A5A5A5A, 3, 1);
    wait_idle();
    r_last_cfg = 1'b1;

    issue(64'h8000_0013, 1, 8'h08, 64'h00000000_77000000, 64'h8000_0010, 0, 0, 3, 1);
    wait_idle();

    r_lat = 3; r_data_cfg = 64'h0F0E0D0C0B0A0908;
    issue(64'h8000_0200, 0, 8'h00, 0, 64'h8000_0200, 0, 64'h0F0E0D0C0B0A0908, 6, 1);
    issue(64'h8000_0208, 0, 8'h00, 0, 64'h8000_0208, 0, 64'h0F0E0D0C0B0A0908, 6, 1);
    check("busy gnt with rvalid", 64'(rv_at_gnt), 1);
    check("busy gnt wait cycles", last_waits, 4);
    wait_idle();
    r_lat = 0;

    aw_lat = 20; w_lat = 20;
    issue(64'h8000_0300, 1, 8'hFF, 64'h1111111111111111, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    rst_i = 1'b1; req_i = 1'b1;
    #2;
    check("gnt blocked in reset", 64'(gnt_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0; req_i = 1'b0;
    #2;
    check("mid-reset valids", {axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready}, 0);
    check("mid-reset rvalid/err", {rvalid_o, err_o}, 0);
    check("mid-reset rdata", rdata_o, 0);
    aw_lat = 0; w_lat = 0;
    issue(64'h8000_0400, 1, 8'h81, 64'h8000000000000001, 64'h8000_0400, 0, 0, 3, 1);
    check("post-reset gnt immediate", last_waits, 0);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
